shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller for the 32-bit right-shift/rotate datapath. It accepts one operand per transaction and applies the fixed-distance shift stages serially, one stage per clock, with a single shared register. This replaces a fully unrolled combinational barrel shifter where area matters more than latency. It sits between the ALU operand mux and the result writeback, using valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 32: operand width. Must be a power of two, at least 2.
- STAGES, $clog2(WIDTH): number of shift stages. It is derived and must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  operand.
- in_amt  in  STAGES  shift distance, 0..WIDTH-1.
- in_sra  in  1  1 = arithmetic fill with the operand MSB; 0 = zero fill.
- in_rotate  in  1  1 = rotate right. Overrides in_sra.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.

## Operation
- States: IDLE, SHIFT, HOLD.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: load in_data into acc, in_amt into amt_q, and the mode bits.
  - Set fill_q = in_sra & in_data[WIDTH-1].
  - Set stage index k = STAGES-1, then go to SHIFT.
- **SHIFT**
  - in_ready=0. Each cycle, apply stage k: acc = acc >> 2^k if amt_q[k]=1, otherwise acc is unchanged.
  - Vacated top 2^k bits:
    - rotate: the low 2^k bits of acc.
    - otherwise: fill_q replicated.
  - Decrement k. After stage 0, go to HOLD.
  - The stage sequence is fixed, largest first (16,8,4,2,1 for WIDTH=32). Stages with a 0 amount bit are not skipped.
- **HOLD**
  - out_valid=1, out_data=acc.
  - On out_ready go to IDLE. The next request can be accepted on the following cycle.
- Mode priority: in_rotate=1 ignores in_sra. in_sra=0 with in_rotate=0 is a logical shift.
- The fill bit is the MSB of the original operand, captured at accept. It is not re-sampled from the intermediate acc.
- in_amt=0 still takes the full sequence. The result equals the operand.
- in_valid while not in IDLE is not accepted. Upstream must hold its request.
- out_data is driven from acc in all states. It is only meaningful while out_valid=1 and is stable until out_ready.

## Timing
- Reset values:
  - state=IDLE, acc=0, amt_q=0, fill_q=0, k=STAGES-1.
  - out_valid=0, out_data=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first cycle after reset is released.
- Latency: for an accept at edge E0, stages are applied at E1..E_STAGES and out_valid rises at E_STAGES (5 edges for WIDTH=32).
- Throughput: one result per STAGES+2 cycles when out_ready is held high (7 for WIDTH=32).
- out_valid is registered, and in_ready is decoded from state only. Neither has a combinational path from in_valid or out_ready.
- Reset mid-transaction: the in-flight operation is discarded. Next edge: IDLE, out_valid=0, no result is emitted.
- Backpressure: HOLD persists indefinitely with out_data unchanged while out_ready=0.

## Structure
- Package shift_pkg holds:
  - the state enum (IDLE, SHIFT, HOLD);
  - the mode encoding constants (SH_LOGIC, SH_ARITH, SH_ROT).
- Sub-module shift_stage:
  - Combinational, one stage: shifts by 2^k with a selectable fill bit or rotate.
  - Selects between the shifted and the unshifted word with an enable.
  - Built from mux2to1 instances.
  - The sequencer instantiates one shift_stage and drives k from its counter, so the datapath is shared across cycles.
- FSM, counter and acc register live in shift_sequencer.

## Test plan
- Logical shift: in_data=32'hF000_000F, amt=4, sra=0, rot=0 -> out_data=32'h0F00_0000, out_valid rises exactly 5 edges after accept.
- Arithmetic shift: in_data=32'h8000_0000, amt=31, sra=1 -> 32'hFFFF_FFFF. Same operand with sra=0 -> 32'h0000_0001.
- Rotate with sra=1, amt=8 on 32'h1234_5678 -> 32'h7812_3456 (rotate overrides sra). amt=0 -> 32'h1234_5678 after full latency.
- Backpressure and busy:
  - Hold out_ready=0 for 10 cycles in HOLD -> out_data constant, in_ready=0.
  - A second in_valid during SHIFT is not accepted until the cycle after the out_ready handshake.
- Reset mid-operation: drop rst_n for one cycle at the 3rd SHIFT cycle -> out_valid stays 0, in_ready=1 after release, and the next request produces a correct result.
- Random regression: 1000 random operand/amt/mode triples with random out_ready stalls, compared against a reference model ((>>), (>>>), rotate).

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the serial shift sequencer: FSM states and shift-mode encoding.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] SH_LOGIC = 2'd0;
  localparam logic [1:0] SH_ARITH = 2'd1;
  localparam logic [1:0] SH_ROT   = 2'd2;

  // Rotate wins over arithmetic; neither flag means a logical shift.
  function automatic logic [1:0] mode_of(input logic sra, input logic rotate);
    if (rotate)   return SH_ROT;
    else if (sra) return SH_ARITH;
    else          return SH_LOGIC;
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer, the leaf cell of the shift stage.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_stage.sv
// One right-shift/rotate stage by 2^k, bypassed when en is low.
module shift_stage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  data,
  input  logic [STAGES-1:0] k,
  input  logic              en,
  input  logic              fill,
  input  logic              rotate,
  output logic [WIDTH-1:0]  res
);

  // One candidate word per distance; k picks which one the cycle uses.
  logic [STAGES-1:0][WIDTH-1:0] cand;
  logic [WIDTH-1:0]             sel_word;

  for (genvar s = 0; s < STAGES; s++) begin : g_dist
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int J = i + (2 ** s);
      if (J < WIDTH) begin : g_keep
        assign cand[s][i] = data[J];
      end else begin : g_vac
        mux2to1 u_fill (
          .a   (fill),
          .b   (data[J-WIDTH]),
          .sel (rotate),
          .y   (cand[s][i])
        );
      end
    end
  end

  assign sel_word = cand[k];

  for (genvar i = 0; i < WIDTH; i++) begin : g_en
    mux2to1 u_en (
      .a   (data[i]),
      .b   (sel_word[i]),
      .sel (en),
      .y   (res[i])
    );
  end

endmodule

// File: rtl/shift_sequencer.sv
// Serial 32-bit right shift/rotate: one power-of-two stage per clock through a
// single shared stage, largest distance first, with valid/ready on both sides.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] in_amt,
  input  logic              in_sra,
  input  logic              in_rotate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  localparam logic [STAGES-1:0] K_TOP = STAGES'(STAGES - 1);
  localparam logic [STAGES-1:0] K_ONE = STAGES'(1);

  state_e            state_q, state_n;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  stage_out;
  logic [STAGES-1:0] amt_q;
  logic [STAGES-1:0] k_q;
  logic [1:0]        mode_q;
  logic              fill_q;
  logic              ready_q;
  logic              valid_q;
  logic              accept;
  logic              last_stage;

  assign accept     = (state_q == IDLE) && in_valid && ready_q;
  assign last_stage = (k_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept)     state_n = SHIFT;
      SHIFT:   if (last_stage) state_n = HOLD;
      HOLD:    if (out_ready)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags are registered from next state so neither output sees a
  // combinational path from in_valid or out_ready, and ready stays low in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (state_n == IDLE);
      valid_q <= (state_n == HOLD);
    end
  end

  // Fill is the original operand MSB, frozen at accept for every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      amt_q  <= '0;
      fill_q <= 1'b0;
      mode_q <= SH_LOGIC;
      k_q    <= K_TOP;
    end else if (accept) begin
      acc_q  <= in_data;
      amt_q  <= in_amt;
      fill_q <= in_sra & in_data[WIDTH-1];
      mode_q <= mode_of(in_sra, in_rotate);
      k_q    <= K_TOP;
    end else if (state_q == SHIFT) begin
      acc_q <= stage_out;
      k_q   <= last_stage ? K_TOP : (k_q - K_ONE);
    end
  end

  shift_stage #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_stage (
    .data   (acc_q),
    .k      (k_q),
    .en     (amt_q[k_q]),
    .fill   (fill_q),
    .rotate (mode_q == SH_ROT),
    .res    (stage_out)
  );

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer against a plain-arithmetic shift model.
module tb_shift_sequencer;

  localparam int W = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [S-1:0] in_amt = '0;
  logic         in_sra = 1'b0;
  logic         in_rotate = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_sra    (in_sra),
    .in_rotate (in_rotate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                         input bit sra, input bit rot);
    logic [2*W-1:0] dd;
    if (rot) begin
      dd = {d, d} >> amt;
      return dd[W-1:0];
    end else if (sra) begin
      return $signed(d) >>> amt;
    end else begin
      return d >> amt;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] d, input int amt, input bit sra, input bit rot);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = amt[S-1:0];
    in_sra    = sra;
    in_rotate = rot;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_logical();
    int lat;
    start_op(32'hF000_000F, 4, 0, 0);
    wait_valid(lat);
    total++; if (lat != 5) begin bad++; $display("FAIL logical_latency: got %0d want 5", lat); end
    total++; if (out_data !== 32'h0F00_0000) begin bad++; $display("FAIL logical_data: got %h want 0f000000", out_data); end
    handshake();
  endtask

  task automatic test_arith();
    int lat;
    start_op(32'h8000_0000, 31, 1, 0);
    wait_valid(lat);
    total++; if (out_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL arith_sra: got %h want ffffffff", out_data); end
    handshake();
    start_op(32'h8000_0000, 31, 0, 0);
    wait_valid(lat);
    total++; if (out_data !== 32'h0000_0001) begin bad++; $display("FAIL arith_srl: got %h want 00000001", out_data); end
    handshake();
  endtask

  task automatic test_rotate();
    int lat;
    start_op(32'h1234_5678, 8, 1, 1);
    wait_valid(lat);
    total++; if (out_data !== 32'h7812_3456) begin bad++; $display("FAIL rotate_8: got %h want 78123456", out_data); end
    handshake();
    start_op(32'h1234_5678, 0, 1, 1);
    wait_valid(lat);
    total++; if (lat != 5) begin bad++; $display("FAIL amt0_latency: got %0d want 5", lat); end
    total++; if (out_data !== 32'h1234_5678) begin bad++; $display("FAIL amt0_data: got %h want 12345678", out_data); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] exp;
    exp = model(32'hA5A5_0F0F, 3, 1, 0);
    start_op(32'hA5A5_0F0F, 3, 1, 0);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_stable c=%0d: data=%h ready=%b valid=%b want data=%h ready=0 valid=1",
                 c, out_data, in_ready, out_valid, exp);
      end
    end
    handshake();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_busy();
    int lat;
    int n;
    logic [W-1:0] d1, d2;
    d1 = 32'h8765_4321;
    d2 = 32'h0000_FF00;
    start_op(d1, 5, 1, 0);
    in_valid = 1'b1; in_data = d2; in_amt = 5'd4; in_sra = 1'b0; in_rotate = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready n=%0d: got %b want 0", n, in_ready); end
      tick();
      n++;
    end
    repeat (2) tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_hold_ready: got %b want 0", in_ready); end
    total++; if (out_data !== model(d1, 5, 1, 0)) begin bad++; $display("FAIL busy_first: got %h want %h", out_data, model(d1, 5, 1, 0)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL busy_after_hs: ready=%b valid=%b want 1 0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_second_accept: ready=%b want 0", in_ready); end
    wait_valid(lat);
    total++; if (lat != 5) begin bad++; $display("FAIL busy_second_latency: got %0d want 5", lat); end
    total++; if (out_data !== model(d2, 4, 0, 1)) begin bad++; $display("FAIL busy_second: got %h want %h", out_data, model(d2, 4, 0, 1)); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    start_op(32'hDEAD_BEEF, 13, 1, 0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL midreset_during: valid=%b ready=%b want 0 0", out_valid, in_ready); end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen = 1;
      tick();
    end
    total++; if (seen) begin bad++; $display("FAIL midreset_no_result: got valid=1 want 0"); end
    start_op(32'h4000_1234, 9, 1, 0);
    wait_valid(lat);
    total++; if (out_data !== model(32'h4000_1234, 9, 1, 0)) begin bad++; $display("FAIL midreset_next: got %h want %h", out_data, model(32'h4000_1234, 9, 1, 0)); end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    int amt;
    int stall;
    bit sra, rot;
    logic [W-1:0] d, exp;
    for (int t = 0; t < 1000; t++) begin
      d     = $urandom;
      amt   = $urandom_range(0, 31);
      sra   = 1'($urandom_range(0, 1));
      rot   = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      exp   = model(d, amt, sra, rot);
      repeat ($urandom_range(0, 2)) tick();
      start_op(d, amt, sra, rot);
      wait_valid(lat);
      total++;
      if (lat != 5 || out_data !== exp) begin
        bad++;
        $display("FAIL random t=%0d d=%h amt=%0d sra=%0d rot=%0d: got %h lat=%0d want %h lat=5",
                 t, d, amt, sra, rot, out_data, lat, exp);
      end
      for (int c = 0; c < stall; c++) begin
        tick();
        total++;
        if (out_data !== exp || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL random_stall t=%0d: got %h valid=%b want %h valid=1", t, out_data, out_valid, exp);
        end
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_rotate();
    test_backpressure();
    test_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
